// File: rtl/nx_ram_1rw_indirect_arb.sv
// nx_ram_1rw_indirect_arb: single-port RAM shared by hw datapath and sw indirect access, with compare and optional parity.
// Optional parity storage/checking enabled by defining NX_RAM_PARITY_EN.
module nx_ram_1rw_indirect_arb #(
    parameter int N_DATA_BITS   = 96,
    parameter int N_ENTRIES     = 512,
    parameter int N_ADDR_BITS   = 9,
    parameter int N_AINDEX_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     sw_cs,
    input  logic                     sw_ce,
    input  logic                     sw_we,
    input  logic [N_ADDR_BITS-1:0]   sw_add,
    input  logic [N_DATA_BITS-1:0]   sw_wdat,
    output logic [N_DATA_BITS-1:0]   sw_rdat,
    output logic                     sw_match,
    output logic [N_AINDEX_BITS-1:0] sw_aindex,
    input  logic                     yield,
    output logic                     grant,
    input  logic                     hw_cs,
    input  logic                     hw_we,
    input  logic [N_ADDR_BITS-1:0]   hw_add,
    input  logic [N_DATA_BITS-1:0]   hw_wdat,
    output logic                     hw_stall,
    output logic [N_DATA_BITS-1:0]   hw_rdat,
    output logic                     hw_rdat_vld,
    output logic                     par_err
);
`ifdef NX_RAM_PARITY_EN
    localparam int W = N_DATA_BITS + 1;
`else
    localparam int W = N_DATA_BITS;
`endif
    logic [W-1:0]             mem [N_ENTRIES];
    logic                     hw_sel, sw_sel, hw_rd, sw_rd, sw_cmp, wr, rng;
    logic [N_ADDR_BITS-1:0]   add;
    logic [N_DATA_BITS-1:0]   wdat, rd_dat;
    logic [W-1:0]             rd_word, wr_word;
    logic [N_DATA_BITS-1:0]   sw_rdat_d, sw_rdat_q, hw_rdat_d, hw_rdat_q;
    logic [N_DATA_BITS-1:0]   cmp1_dat_d, cmp1_dat_q, cmp1_wdat_d, cmp1_wdat_q;
    logic [N_AINDEX_BITS-1:0] cmp1_idx_d, cmp1_idx_q, sw_aindex_d, sw_aindex_q;
    logic                     cmp1_vld_d, cmp1_vld_q, cmp1_rng_d, cmp1_rng_q;
    logic                     sw_match_d, sw_match_q, hw_rdat_vld_d, hw_rdat_vld_q;
    logic                     par_err_d, par_err_q;
    // Single port: the winner's address and data drive the array for this cycle.
    always_comb begin
        hw_sel  = hw_cs & enable & !yield & !rst;
        sw_sel  = sw_cs & !hw_sel & !rst;
        add     = hw_sel ? hw_add : sw_add;
        wdat    = hw_sel ? hw_wdat : sw_wdat;
        rng     = 32'(add) < N_ENTRIES;
        wr      = rng & (hw_sel ? hw_we : (sw_sel & sw_we & !sw_ce));
        hw_rd   = hw_sel & !hw_we;
        sw_rd   = sw_sel & !sw_we & !sw_ce;
        sw_cmp  = sw_sel & sw_ce;
        rd_word = rng ? mem[add] : '0;
        rd_dat  = rd_word[N_DATA_BITS-1:0];
`ifdef NX_RAM_PARITY_EN
        wr_word   = {^wdat, wdat};
        par_err_d = (hw_rd | sw_rd | sw_cmp) & rng & (^rd_word);
`else
        wr_word   = wdat;
        par_err_d = 1'b0;
`endif
    end
    always_ff @(posedge clk)
        if (wr) mem[add] <= wr_word;
    // Compare stage-1 registers are private so an interleaved sw read cannot disturb them.
    always_comb begin
        sw_rdat_d     = sw_rd ? rd_dat : sw_rdat_q;
        hw_rdat_d     = hw_rd ? rd_dat : hw_rdat_q;
        hw_rdat_vld_d = hw_rd;
        cmp1_vld_d    = sw_cmp;
        cmp1_dat_d    = sw_cmp ? rd_dat : cmp1_dat_q;
        cmp1_wdat_d   = sw_cmp ? sw_wdat : cmp1_wdat_q;
        cmp1_idx_d    = sw_cmp ? sw_add[N_AINDEX_BITS-1:0] : cmp1_idx_q;
        cmp1_rng_d    = sw_cmp ? rng : cmp1_rng_q;
        sw_match_d    = cmp1_vld_q ? (cmp1_rng_q & (cmp1_dat_q == cmp1_wdat_q)) : sw_match_q;
        sw_aindex_d   = cmp1_vld_q ? cmp1_idx_q : sw_aindex_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_rdat_q     <= '0;
            hw_rdat_q     <= '0;
            hw_rdat_vld_q <= 1'b0;
            cmp1_vld_q    <= 1'b0;
            cmp1_dat_q    <= '0;
            cmp1_wdat_q   <= '0;
            cmp1_idx_q    <= '0;
            cmp1_rng_q    <= 1'b0;
            sw_match_q    <= 1'b0;
            sw_aindex_q   <= '0;
            par_err_q     <= 1'b0;
        end else begin
            sw_rdat_q     <= sw_rdat_d;
            hw_rdat_q     <= hw_rdat_d;
            hw_rdat_vld_q <= hw_rdat_vld_d;
            cmp1_vld_q    <= cmp1_vld_d;
            cmp1_dat_q    <= cmp1_dat_d;
            cmp1_wdat_q   <= cmp1_wdat_d;
            cmp1_idx_q    <= cmp1_idx_d;
            cmp1_rng_q    <= cmp1_rng_d;
            sw_match_q    <= sw_match_d;
            sw_aindex_q   <= sw_aindex_d;
            par_err_q     <= par_err_d;
        end
    end
    assign grant       = sw_sel;
    assign hw_stall    = hw_cs & !hw_sel;
    assign sw_rdat     = sw_rdat_q;
    assign sw_match    = sw_match_q;
    assign sw_aindex   = sw_aindex_q;
    assign hw_rdat     = hw_rdat_q;
    assign hw_rdat_vld = hw_rdat_vld_q;
    assign par_err     = par_err_q;
endmodule

// File: tb/tb_nx_ram_1rw_indirect_arb.sv
// tb_nx_ram_1rw_indirect_arb: directed and random checks against a cycle-level behavioural model.
module tb_nx_ram_1rw_indirect_arb;
    localparam int DW = 96, NE = 512, AW = 9, IW = 8;
    logic clk = 0, rst = 0, enable = 0, sw_cs = 0, sw_ce = 0, sw_we = 0, yield = 0, hw_cs = 0, hw_we = 0;
    logic [AW-1:0] sw_add = '0, hw_add = '0;
    logic [DW-1:0] sw_wdat = '0, hw_wdat = '0;
    logic [DW-1:0] sw_rdat, hw_rdat;
    logic [IW-1:0] sw_aindex;
    logic sw_match, grant, hw_stall, hw_rdat_vld, par_err;

    nx_ram_1rw_indirect_arb dut (
        .clk(clk), .rst(rst), .enable(enable), .sw_cs(sw_cs), .sw_ce(sw_ce), .sw_we(sw_we),
        .sw_add(sw_add), .sw_wdat(sw_wdat), .sw_rdat(sw_rdat), .sw_match(sw_match),
        .sw_aindex(sw_aindex), .yield(yield), .grant(grant), .hw_cs(hw_cs), .hw_we(hw_we),
        .hw_add(hw_add), .hw_wdat(hw_wdat), .hw_stall(hw_stall), .hw_rdat(hw_rdat),
        .hw_rdat_vld(hw_rdat_vld), .par_err(par_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc_n = 0;
    logic [DW-1:0] ref_mem [NE];
    bit bad [NE];
    logic [DW-1:0] e_sw_rdat = '0, e_hw_rdat = '0;
    logic [IW-1:0] e_idx = '0;
    logic e_hw_vld = 0, e_match = 0, e_par = 0;
    typedef struct { int due; logic hit; logic [IW-1:0] idx; } cmp_t;
    cmp_t cq[$];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc_n);
        end
    endtask

    task automatic check_regs();
        chk("sw_rdat", sw_rdat, e_sw_rdat);
        chk("hw_rdat", hw_rdat, e_hw_rdat);
        chk("hw_rdat_vld", hw_rdat_vld, e_hw_vld);
        chk("sw_match", sw_match, e_match);
        chk("sw_aindex", sw_aindex, e_idx);
        chk("par_err", par_err, e_par);
    endtask

    task automatic model_clear();
        e_sw_rdat = '0; e_hw_rdat = '0; e_idx = '0;
        e_hw_vld = 0; e_match = 0; e_par = 0;
        cq.delete();
    endtask

    task automatic sw(input logic cs, input logic ce, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        sw_cs = cs; sw_ce = ce; sw_we = we; sw_add = a; sw_wdat = d;
    endtask

    task automatic hw(input logic cs, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        hw_cs = cs; hw_we = we; hw_add = a; hw_wdat = d;
    endtask

    // One clock: check arbitration mid-cycle, then apply the access to the model and check registered outputs.
    task automatic cyc();
        logic hs, ss;
        #4;
        hs = hw_cs & enable & !yield;
        ss = sw_cs & !hs;
        chk("grant", grant, ss);
        chk("hw_stall", hw_stall, hw_cs & !hs);
        @(posedge clk);
        #1;
        cyc_n++;
        e_hw_vld = hs & !hw_we;
        e_par = 0;
        if (hs) begin
            if (hw_we) begin ref_mem[hw_add] = hw_wdat; bad[hw_add] = 0; end
            else begin e_hw_rdat = ref_mem[hw_add]; e_par = bad[hw_add]; end
        end
        if (ss) begin
            if (sw_ce) begin
                cq.push_back('{cyc_n + 1, ref_mem[sw_add] == sw_wdat, sw_add[IW-1:0]});
                e_par = bad[sw_add];
            end else if (sw_we) begin
                ref_mem[sw_add] = sw_wdat; bad[sw_add] = 0;
            end else begin
                e_sw_rdat = ref_mem[sw_add]; e_par = bad[sw_add];
            end
        end
        while (cq.size() > 0 && cq[0].due == cyc_n) begin
            e_match = cq[0].hit;
            e_idx = cq[0].idx;
            void'(cq.pop_front());
        end
        check_regs();
    endtask

    function automatic logic [DW-1:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        #1 rst = 1;
        #1 check_regs();
        @(posedge clk); #1 rst = 0;
        // sw write then read with the table disabled
        sw(1, 0, 1, 5, 96'hA5); cyc();
        sw(1, 0, 0, 5, 0); cyc();
        sw(0, 0, 0, 0, 0); cyc();
        // compare hit then miss at the top address
        sw(1, 0, 1, 9'h1FF, 96'h1234); cyc();
        sw(1, 1, 0, 9'h1FF, 96'h1234); cyc();
        sw(0, 0, 0, 0, 0); cyc(); cyc();
        sw(1, 1, 1, 9'h1FF, 96'h1235); cyc();
        sw(0, 0, 0, 0, 0); cyc(); cyc();
        // hw write/read latency
        enable = 1;
        hw(1, 1, 3, 96'hDEAD); cyc();
        hw(1, 0, 3, 0); cyc();
        hw(0, 0, 0, 0); cyc();
        // table disabled blocks hw
        enable = 0;
        hw(1, 0, 3, 0); cyc(); cyc(); cyc();
        // hw priority and yield
        enable = 1;
        hw(1, 0, 3, 0); sw(1, 0, 0, 5, 0); cyc(); cyc();
        yield = 1; cyc();
        yield = 0; cyc();
        hw(0, 0, 0, 0); sw(0, 0, 0, 0, 0); cyc();
        // async reset during compare stage 1
        sw(1, 1, 0, 5, 96'hA5); cyc();
        sw(0, 0, 0, 0, 0);
        #2 rst = 1;
        #1 model_clear(); check_regs();
        @(posedge clk); #1 rst = 0;
        cyc(); cyc(); cyc();
`ifdef NX_RAM_PARITY_EN
        hw(1, 1, 7, 96'h77); cyc();
        hw(0, 0, 0, 0);
        dut.mem[7][0] = ~dut.mem[7][0];
        ref_mem[7][0] = ~ref_mem[7][0];
        bad[7] = 1;
        hw(1, 0, 7, 0); cyc();
        hw(0, 0, 0, 0); cyc();
`endif
        // random traffic over a small initialised window
        enable = 0;
        for (int i = 0; i < 16; i++) begin sw(1, 0, 1, AW'(i), rnd96()); cyc(); end
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 15));
            enable = $urandom_range(0, 3) != 0;
            yield = $urandom_range(0, 4) == 0;
            hw($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, 15)), rnd96());
            sw($urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 1), a,
               $urandom_range(0, 1) ? ref_mem[a] : rnd96());
            cyc();
        end
        hw(0, 0, 0, 0); sw(0, 0, 0, 0, 0); yield = 0;
        cyc(); cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
